// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: periodic trigger, synchronised echo width
// measurement with timeouts, and active-low distance zone indicators.
module ultrasonic_ranger #(
  parameter int CNT_W          = 22,
  parameter int TRIG_CYCLES    = 500,
  parameter int PERIOD_CYCLES  = 3000000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int NUM_ZONES      = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       echo,
  input  logic [NUM_ZONES*CNT_W-1:0] zone_thr,
  output logic                       trig,
  output logic [CNT_W-1:0]           echo_cnt,
  output logic                       meas_valid,
  output logic                       timeout,
  output logic                       busy,
  output logic [NUM_ZONES-1:0]       zone_n
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TRIG = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_MEAS = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LIM    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     per_q, per_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 meta_q, echo_s_q, echo_sd_q;
  logic                 trig_q, busy_q, mv_q, to_q;
  logic [CNT_W-1:0]     echo_cnt_q;
  logic [NUM_ZONES-1:0] zone_n_q, zone_new;
  logic                 rise, fall;
  logic                 mv_set, to_set;
  logic [CNT_W-1:0]     lo, hi;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q    <= 1'b0;
      echo_s_q  <= 1'b0;
      echo_sd_q <= 1'b0;
    end else begin
      meta_q    <= echo;
      echo_s_q  <= meta_q;
      echo_sd_q <= echo_s_q;
    end
  end

  assign rise = echo_s_q & ~echo_sd_q;
  assign fall = ~echo_s_q & echo_sd_q;

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    cnt_d   = cnt_q;
    mv_set  = 1'b0;
    to_set  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        per_d = '0;
        cnt_d = '0;
        if (enable) state_d = S_TRIG;
      end
      S_TRIG: begin
        per_d = sat_inc(per_q);
        if (cnt_q >= TRIG_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_WAIT: begin
        per_d = sat_inc(per_q);
        // edge-qualified, so an echo already high on entry is ignored
        if (rise) begin
          state_d = S_MEAS;
          cnt_d   = CNT_ONE;
        end else if (cnt_q >= TO_LAST) begin
          state_d = S_HOLD;
          to_set  = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_MEAS: begin
        per_d = sat_inc(per_q);
        if (fall) begin
          state_d = S_HOLD;
          mv_set  = 1'b1;
        end else if (cnt_q >= TO_LIM) begin
          state_d = S_HOLD;
          to_set  = 1'b1;
        end else if (echo_s_q) begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_HOLD: begin
        per_d = sat_inc(per_q);
        if (per_q >= PER_LAST) begin
          per_d   = '0;
          cnt_d   = '0;
          state_d = enable ? S_TRIG : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        per_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // bounds are ascending, so at most one window can contain the count
  always_comb begin
    zone_new = '1;
    lo       = '0;
    hi       = '0;
    for (int k = 0; k < NUM_ZONES; k++) begin
      hi = zone_thr[k*CNT_W +: CNT_W];
      if (cnt_q >= lo && cnt_q < hi) zone_new[k] = 1'b0;
      lo = hi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      per_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      mv_q       <= 1'b0;
      to_q       <= 1'b0;
      echo_cnt_q <= '0;
      zone_n_q   <= '1;
    end else begin
      trig_q <= (state_d == S_TRIG);
      busy_q <= (state_d != S_IDLE);
      mv_q   <= mv_set;
      to_q   <= to_set;
      if (mv_set) begin
        echo_cnt_q <= cnt_q;
        zone_n_q   <= zone_new;
      end else if (to_set) begin
        zone_n_q <= '1;
      end
    end
  end

  assign trig       = trig_q;
  assign busy       = busy_q;
  assign meas_valid = mv_q;
  assign timeout    = to_q;
  assign echo_cnt   = echo_cnt_q;
  assign zone_n     = zone_n_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: directed vectors against hand-computed
// trigger timing, echo widths, zones and timeouts.
module tb_ultrasonic_ranger;

  localparam int CW = 22;
  localparam int NZ = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic           echo = 1'b0;
  logic [NZ*CW-1:0] thr = {22'd60, 22'd40, 22'd20};
  logic           trig;
  logic [CW-1:0]  echo_cnt;
  logic           meas_valid;
  logic           timeout;
  logic           busy;
  logic [NZ-1:0]  zone_n;

  int n_chk = 0;
  int n_err = 0;

  int cyc = 0;
  logic trig_p = 1'b0;
  int rise_last = 0;
  int rise_prev = 0;
  int n_rise = 0;
  int hi_run = 0;
  int hi_len = 0;
  int n_mv = 0;
  int n_to = 0;
  int both = 0;
  int trig_nobusy = 0;
  int busy_drop = 0;
  logic busy_watch = 1'b0;

  ultrasonic_ranger #(
    .CNT_W(CW),
    .TRIG_CYCLES(10),
    .PERIOD_CYCLES(200),
    .TIMEOUT_CYCLES(100),
    .NUM_ZONES(NZ)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .echo(echo),
    .zone_thr(thr),
    .trig(trig),
    .echo_cnt(echo_cnt),
    .meas_valid(meas_valid),
    .timeout(timeout),
    .busy(busy),
    .zone_n(zone_n)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    trig_p <= trig;
    if (trig && !trig_p) begin
      n_rise    <= n_rise + 1;
      rise_prev <= rise_last;
      rise_last <= cyc + 1;
    end
    hi_run <= trig ? hi_run + 1 : 0;
    if (!trig && trig_p) hi_len <= hi_run;
    if (meas_valid) n_mv <= n_mv + 1;
    if (timeout) n_to <= n_to + 1;
    if (meas_valid && timeout) both <= both + 1;
    if (trig && !busy) trig_nobusy <= trig_nobusy + 1;
    if (busy_watch && !busy) busy_drop <= busy_drop + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_trig_low(input string tag);
    for (int i = 0; i < 500 && !trig; i++) step();
    chk({tag, "_rise"}, trig, 1);
    for (int i = 0; i < 50 && trig; i++) step();
    chk({tag, "_fall"}, trig, 0);
  endtask

  task automatic wait_mv(input string tag);
    for (int i = 0; i < 300 && !meas_valid; i++) step();
    chk({tag, "_mv"}, meas_valid, 1);
  endtask

  task automatic measure(input string tag, input int w,
                         input logic [2:0] zexp);
    wait_trig_low(tag);
    chk({tag, "_per"}, rise_last - rise_prev, 200);
    echo = 1'b1;
    steps(w);
    echo = 1'b0;
    wait_mv(tag);
    chk({tag, "_cnt"}, echo_cnt, w);
    chk({tag, "_zone"}, zone_n, zexp);
    step();
    chk({tag, "_mv1"}, meas_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int e0, mv0, to0, r0;
    steps(2);
    chk("rst_trig", trig, 0);
    chk("rst_cnt", echo_cnt, 0);
    chk("rst_mv", meas_valid, 0);
    chk("rst_to", timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_zone", zone_n, 3'b111);
    rst_n = 1'b1;
    enable = 1'b1;

    // first cycle: trigger width, 30-cycle echo
    wait_trig_low("t1");
    chk("t1_hi", hi_len, 10);
    busy_watch = 1'b1;
    echo = 1'b1;
    steps(30);
    echo = 1'b0;
    wait_mv("t1");
    chk("t1_cnt", echo_cnt, 30);
    chk("t1_zone", zone_n, 3'b101);
    step();
    chk("t1_mv1", meas_valid, 0);

    measure("w5", 5, 3'b110);
    chk("w5_hi", hi_len, 10);
    measure("w60", 60, 3'b111);
    measure("w59", 59, 3'b011);

    // no echo at all
    wait_trig_low("noe");
    chk("noe_per", rise_last - rise_prev, 200);
    e0 = cyc;
    mv0 = n_mv;
    for (int i = 0; i < 300 && !timeout; i++) step();
    chk("noe_to", timeout, 1);
    chk("noe_lat", cyc - e0, 100);
    chk("noe_zone", zone_n, 3'b111);
    chk("noe_cnt", echo_cnt, 59);
    step();
    chk("noe_to1", timeout, 0);
    chk("noe_nomv", n_mv, mv0);

    // echo stuck high past the width limit
    wait_trig_low("stk");
    chk("stk_per", rise_last - rise_prev, 200);
    echo = 1'b1;
    for (int i = 0; i < 300 && !timeout; i++) step();
    chk("stk_to", timeout, 1);
    chk("stk_nomv", n_mv, mv0);
    chk("stk_cnt", echo_cnt, 59);
    chk("stk_zone", zone_n, 3'b111);

    // echo still high over the next trigger: stale, must be ignored
    wait_trig_low("stl");
    chk("stl_per", rise_last - rise_prev, 200);
    to0 = n_to;
    steps(20);
    chk("stl_nomv", n_mv, mv0);
    chk("stl_noto", n_to, to0);
    echo = 1'b0;
    steps(5);
    echo = 1'b1;
    steps(25);
    echo = 1'b0;
    wait_mv("stl");
    chk("stl_cnt", echo_cnt, 25);
    chk("stl_zone", zone_n, 3'b101);
    chk("busy_run", busy_drop, 0);
    busy_watch = 1'b0;

    // disable in the middle of a measurement
    wait_trig_low("dis");
    echo = 1'b1;
    steps(10);
    enable = 1'b0;
    steps(20);
    echo = 1'b0;
    wait_mv("dis");
    chk("dis_cnt", echo_cnt, 30);
    for (int i = 0; i < 400 && busy; i++) step();
    chk("dis_idle", busy, 0);
    chk("dis_end", cyc - rise_last, 200);
    r0 = n_rise;
    steps(300);
    chk("dis_norise", n_rise, r0);
    chk("dis_trig", trig, 0);
    chk("dis_busy", busy, 0);

    // reset in the middle of a measurement
    enable = 1'b1;
    wait_trig_low("mr");
    echo = 1'b1;
    steps(10);
    chk("mr_busy0", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_trig", trig, 0);
    chk("mr_cnt", echo_cnt, 0);
    chk("mr_mv", meas_valid, 0);
    chk("mr_to", timeout, 0);
    chk("mr_busy", busy, 0);
    chk("mr_zone", zone_n, 3'b111);
    echo = 1'b0;
    steps(3);
    rst_n = 1'b1;
    wait_trig_low("mr2");
    chk("mr2_hi", hi_len, 10);
    chk("mr2_busy", busy, 1);

    chk("mv_to_excl", both, 0);
    chk("trig_busy", trig_nobusy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ultrasonic_ranger.md
Name: ultrasonic_ranger

Overview:
Parametrised successor to the single-channel trigger/echo/LED ranging chain. One FSM issues periodic trigger pulses, synchronises the echo, measures echo pulse width in clock cycles, and detects timeouts. The measured count is mapped to NUM_ZONES active-low zone indicators. It sits between the ultrasonic sensor pins and the board LEDs, and exposes the raw count to other logic.

Parameters:
CNT_W, 22, width of all cycle counters and thresholds
TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz)
PERIOD_CYCLES, 3000000, trigger-to-trigger period in clk cycles (60 ms)
TIMEOUT_CYCLES, 1500000, max cycles waiting for echo rise, and max echo width
NUM_ZONES, 3, number of distance zones / indicator outputs

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = run measurement cycles; 0 = stop after current cycle
echo  in  1  sensor echo, asynchronous to clk
zone_thr  in  NUM_ZONES*CNT_W  zone upper bounds; slice k = thr[k], ascending
trig  out  1  sensor trigger pulse
echo_cnt  out  CNT_W  last valid echo width in cycles
meas_valid  out  1  one-cycle strobe: echo_cnt updated
timeout  out  1  one-cycle strobe: cycle ended without a valid echo
busy  out  1  1 whenever FSM is not IDLE
zone_n  out  NUM_ZONES  active-low zone indicators, bit 0 = nearest

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; trig=0, echo_cnt=0, meas_valid=0, timeout=0, busy=0, zone_n=all ones; synchroniser flops=0.
- echo passes a 2-flop synchroniser -> echo_s; echo_s_d is a 1-cycle delay; rise = echo_s & ~echo_s_d; fall = ~echo_s & echo_s_d.
- States: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE: trig=0. enable=1 -> TRIG next cycle; period counter cleared to 0.
- TRIG: trig=1 for exactly TRIG_CYCLES cycles, then -> WAIT_RISE. The period counter increments every cycle from TRIG entry through HOLDOFF.
- WAIT_RISE: wait counter increments. On rise -> MEASURE with width counter=1. A stale high echo (echo_s already 1 on entry) is ignored until a genuine rise. If the wait counter reaches TIMEOUT_CYCLES -> pulse timeout, -> HOLDOFF.
- MEASURE: width counter increments while echo_s=1. On fall: echo_cnt <= width counter, meas_valid pulses in the same cycle echo_cnt changes, zones updated, -> HOLDOFF. Required: echo_s high for W cycles gives echo_cnt=W. If the width counter reaches TIMEOUT_CYCLES before fall -> pulse timeout, echo_cnt unchanged, -> HOLDOFF.
- HOLDOFF: when the period counter reaches PERIOD_CYCLES-1: enable=1 -> TRIG (counter cleared); else -> IDLE. Trigger rising edges are therefore exactly PERIOD_CYCLES apart while enabled.
- enable=0 mid-cycle never truncates trig or a measurement; the current cycle completes, then the FSM returns to IDLE.
- Zone mapping, registered on meas_valid: bit k low iff echo_cnt < thr[k] and (k==0 or echo_cnt >= thr[k-1]). Count >= thr[NUM_ZONES-1] -> all ones.
- On timeout, zone_n = all ones. Otherwise zone_n holds between updates. At most one bit is low.
- Counters saturate and never wrap. All arithmetic is unsigned, CNT_W bits.
- meas_valid and timeout never assert in the same cycle.
- busy=1 in TRIG, WAIT_RISE, MEASURE and HOLDOFF.

Test Plan:
Bench params for all scenarios: TRIG_CYCLES=10, PERIOD_CYCLES=200, TIMEOUT_CYCLES=100, thr={20,40,60}.
1. enable=1 after reset -> trig high exactly 10 cycles; next trig rise exactly 200 cycles later; busy=1 throughout.
2. echo high 30 cycles after trig -> meas_valid one cycle, echo_cnt=30, zone_n=3'b101. Repeat with 5 -> 3'b110; 59 -> 3'b011; 60 -> 3'b111.
3. No echo -> timeout pulses 100 cycles after WAIT_RISE entry; zone_n=3'b111; echo_cnt keeps its previous value; next trig is still on schedule.
4. echo stuck high 150 cycles -> timeout at width 100, no meas_valid. Then echo held high across the next trigger -> ignored until low then high.
5. Drop enable during MEASURE of a 30-cycle echo -> echo_cnt=30 still reported, FSM reaches IDLE at period end, no further trig, busy=0.
6. Assert rst_n=0 mid-MEASURE -> all outputs at reset values immediately; after release with enable=1, a fresh trig pulse of 10 cycles follows.
